// File: rtl/idle_pattern_ml.sv
// Idle pattern generator: BS/SR, BF, BF, BS/SR, VB-ID, Mvid, Maud, then dummy fill to PERIOD symbols per pattern.
// All outputs are registered, so the symbols for the state in cycle t appear in cycle t+1.
module idle_pattern_ml #(
  parameter int MAX_LANES   = 4,
  parameter int PERIOD      = 8192,
  parameter int SR_INTERVAL = 512
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sched_idle_en,
  input  logic [2:0]             cfg_lane_count,
  input  logic [7:0]             cfg_mvid,
  input  logic [7:0]             cfg_maud,
  output logic [8*MAX_LANES-1:0] idle_symbols,
  output logic [MAX_LANES-1:0]   idle_control_sym_flag,
  output logic                   idle_activate_en,
  output logic                   idle_pattern_start
);

  localparam int              PCW     = (SR_INTERVAL > 1) ? $clog2(SR_INTERVAL) : 1;
  localparam logic [15:0]     CNT_END = 16'(PERIOD - 1);
  localparam logic [PCW-1:0]  PC_END  = PCW'(SR_INTERVAL - 1);

  typedef enum logic [3:0] {IDLE, BS1, BS2, BS3, BS4, VBID, MVID, MAUD, DUMMY} state_t;

  state_t                 state_q, state_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [PCW-1:0]         pcnt_q, pcnt_d;
  logic                   first_q, first_d;
  logic [2:0]             lanes_q, lanes_d;
  logic [7:0]             mvid_q, mvid_d, maud_q, maud_d;
  logic                   enter_bs1;

  logic [8*MAX_LANES-1:0] sym_q, sym_d;
  logic [MAX_LANES-1:0]   flag_q, flag_d;
  logic                   act_q, act_d, start_q, start_d;
  logic [7:0]             sym;
  logic                   kflag, sr_pat;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pcnt_d    = pcnt_q;
    first_d   = first_q;
    lanes_d   = lanes_q;
    mvid_d    = mvid_q;
    maud_d    = maud_q;
    enter_bs1 = 1'b0;
    if (!sched_idle_en) begin
      state_d = IDLE;
      cnt_d   = '0;
      pcnt_d  = '0;
      first_d = 1'b1;
    end else begin
      unique case (state_q)
        IDLE:  begin state_d = BS1; enter_bs1 = 1'b1; end
        BS1:   state_d = BS2;
        BS2:   state_d = BS3;
        BS3:   state_d = BS4;
        BS4:   state_d = VBID;
        VBID:  state_d = MVID;
        MVID:  state_d = MAUD;
        MAUD:  state_d = DUMMY;
        DUMMY: begin
          if (cnt_q == CNT_END) begin
            state_d   = BS1;
            enter_bs1 = 1'b1;
            first_d   = 1'b0;
            pcnt_d    = (pcnt_q == PC_END) ? '0 : pcnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
      cnt_d = enter_bs1 ? 16'd0 : cnt_q + 16'd1;
      // Pattern configuration is frozen at the pattern boundary.
      if (enter_bs1) begin
        lanes_d = (cfg_lane_count == 3'd2 || cfg_lane_count == 3'd4) ? cfg_lane_count : 3'd1;
        mvid_d  = cfg_mvid;
        maud_d  = cfg_maud;
      end
    end
  end

  always_comb begin
    sym     = 8'h00;
    kflag   = 1'b0;
    act_d   = 1'b1;
    start_d = 1'b0;
    sr_pat  = first_q || (pcnt_q == '0);
    unique case (state_q)
      BS1:     begin sym = sr_pat ? 8'h0F : 8'hBC; kflag = 1'b1; act_d = 1'b0; start_d = 1'b1; end
      BS2,
      BS3:     begin sym = 8'hBD; kflag = 1'b1; act_d = 1'b0; end
      BS4:     begin sym = sr_pat ? 8'h0F : 8'hBC; kflag = 1'b1; end
      VBID:    sym = 8'h08;
      MVID:    sym = mvid_q;
      MAUD:    sym = maud_q;
      DUMMY:   act_d = (cnt_q != CNT_END);
      default: ;
    endcase
    sym_d  = '0;
    flag_d = '0;
    for (int l = 0; l < MAX_LANES; l++) begin
      if (3'(l) < lanes_q) begin
        sym_d[8*l +: 8] = sym;
        flag_d[l]       = kflag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      first_q <= 1'b1;
      lanes_q <= 3'd1;
      mvid_q  <= '0;
      maud_q  <= '0;
      sym_q   <= '0;
      flag_q  <= '0;
      act_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      first_q <= first_d;
      lanes_q <= lanes_d;
      mvid_q  <= mvid_d;
      maud_q  <= maud_d;
      sym_q   <= sym_d;
      flag_q  <= flag_d;
      act_q   <= act_d;
      start_q <= start_d;
    end
  end

  assign idle_symbols          = sym_q;
  assign idle_control_sym_flag = flag_q;
  assign idle_activate_en      = act_q;
  assign idle_pattern_start    = start_q;

endmodule

// File: tb/tb_idle_pattern_ml.sv
// Randomized bench for idle_pattern_ml; the reference model derives each output from how long enable has been held.
module tb_idle_pattern_ml;

  localparam int MAX_LANES   = 4;
  localparam int PERIOD      = 16;
  localparam int SR_INTERVAL = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sched_idle_en;
  logic [2:0]  cfg_lane_count;
  logic [7:0]  cfg_mvid, cfg_maud;
  logic [31:0] idle_symbols;
  logic [3:0]  idle_control_sym_flag;
  logic        idle_activate_en, idle_pattern_start;
  wire  [37:0] obs = {idle_symbols, idle_control_sym_flag, idle_activate_en, idle_pattern_start};

  int          checks = 0;
  int          failures = 0;
  int          rl = 0;           // consecutive edges with enable high since idle/reset
  int          lat_lanes = 1;
  logic [7:0]  lat_mvid = 8'h00, lat_maud = 8'h00;
  logic [37:0] exp_all = '0;

  idle_pattern_ml #(.MAX_LANES(MAX_LANES), .PERIOD(PERIOD), .SR_INTERVAL(SR_INTERVAL)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .sched_idle_en         (sched_idle_en),
    .cfg_lane_count        (cfg_lane_count),
    .cfg_mvid              (cfg_mvid),
    .cfg_maud              (cfg_maud),
    .idle_symbols          (idle_symbols),
    .idle_control_sym_flag (idle_control_sym_flag),
    .idle_activate_en      (idle_activate_en),
    .idle_pattern_start    (idle_pattern_start)
  );

  always #5 clk = ~clk;

  // One clock edge of the reference model; leaves the bench 1 time unit after the edge.
  task automatic tick();
    logic en_s, rst_s;
    logic [2:0] lc;
    logic [7:0] mv, ma, s;
    logic [31:0] es;
    logic [3:0]  ef;
    logic k, sr, ea, est;
    int p, pat;
    en_s = sched_idle_en; rst_s = rst_n; lc = cfg_lane_count; mv = cfg_mvid; ma = cfg_maud;
    @(posedge clk);
    if (!rst_s) begin
      rl = 0; lat_lanes = 1; lat_mvid = 8'h00; lat_maud = 8'h00; exp_all = '0;
    end else begin
      es = '0; ef = '0; ea = 1'b1; est = 1'b0;
      if (rl > 0) begin
        p   = (rl - 1) % PERIOD;
        pat = (rl - 1) / PERIOD;
        sr  = (pat % SR_INTERVAL) == 0;
        k   = (p <= 3);
        case (p)
          0, 3:    s = sr ? 8'h0F : 8'hBC;
          1, 2:    s = 8'hBD;
          4:       s = 8'h08;
          5:       s = lat_mvid;
          6:       s = lat_maud;
          default: s = 8'h00;
        endcase
        ea  = !(p < 3 || p == PERIOD - 1);
        est = (p == 0);
        for (int l = 0; l < MAX_LANES; l++) begin
          if (l < lat_lanes) begin
            es[8*l +: 8] = s;
            ef[l]        = k;
          end
        end
      end
      exp_all = {es, ef, ea, est};
      rl = en_s ? rl + 1 : 0;
      if (rl > 0 && ((rl - 1) % PERIOD) == 0) begin
        lat_lanes = (lc == 3'd2 || lc == 3'd4) ? int'(lc) : 1;
        lat_mvid  = mv;
        lat_maud  = ma;
      end
    end
    #1;
  endtask

  task automatic go_idle();
    sched_idle_en = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sched_idle_en = 1'b0;
    cfg_lane_count = 3'd4; cfg_mvid = 8'h00; cfg_maud = 8'h00;
    #1;
    checks++;
    if (obs !== 38'd0) begin failures++; $display("FAIL reset_async got=%h exp=0", obs); end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) rst_n = 1'b1;
      checks++;
      if (obs !== exp_all) begin failures++; $display("FAIL reset_hold i=%0d got=%h exp=%h", i, obs, exp_all); end
    end
    tick();
    checks++;
    if (idle_activate_en !== 1'b1 || idle_symbols !== 32'd0) begin
      failures++; $display("FAIL reset_first_idle act=%b sym=%h exp act=1 sym=0", idle_activate_en, idle_symbols);
    end
  endtask

  task automatic test_basic();
    int starts = 0;
    go_idle();
    cfg_lane_count = 3'd4; cfg_mvid = 8'($urandom); cfg_maud = 8'($urandom);
    sched_idle_en = 1'b1;
    for (int i = 0; i < PERIOD + 1; i++) begin
      tick();
      if (idle_pattern_start) starts++;
      checks++;
      if (obs !== exp_all) begin failures++; $display("FAIL basic i=%0d got=%h exp=%h", i, obs, exp_all); end
      if (i == 1) begin
        checks++;
        if (idle_symbols !== 32'h0F0F0F0F || idle_control_sym_flag !== 4'hF) begin
          failures++; $display("FAIL basic_first_sr sym=%h flag=%b exp 0f0f0f0f/1111", idle_symbols, idle_control_sym_flag);
        end
      end
    end
    checks++;
    if (starts != 1) begin failures++; $display("FAIL basic_start_pulses got=%0d exp=1", starts); end
  endtask

  task automatic test_sr_interval();
    logic [7:0] seq [5];
    int idx [5];
    int n = 0;
    logic [7:0] want;
    go_idle();
    cfg_lane_count = 3'd2; cfg_mvid = 8'($urandom); cfg_maud = 8'($urandom);
    sched_idle_en = 1'b1;
    for (int i = 0; i < 5 * PERIOD + 1; i++) begin
      tick();
      if (idle_pattern_start && n < 5) begin seq[n] = idle_symbols[7:0]; idx[n] = i; n++; end
      checks++;
      if (obs !== exp_all) begin failures++; $display("FAIL sr_interval i=%0d got=%h exp=%h", i, obs, exp_all); end
    end
    checks++;
    if (n != 5) begin failures++; $display("FAIL sr_pattern_count got=%0d exp=5", n); end
    for (int j = 0; j < n; j++) begin
      want = (j == 0 || j == 4) ? 8'h0F : 8'hBC;
      checks++;
      if (seq[j] !== want || (j > 0 && idx[j] - idx[j-1] != PERIOD)) begin
        failures++; $display("FAIL sr_seq pat=%0d got=%h exp=%h spacing ok=%0d", j + 1, seq[j], want, (j == 0) || (idx[j] - idx[j-1] == PERIOD));
      end
    end
  endtask

  task automatic test_abort();
    go_idle();
    cfg_lane_count = 3'd4; sched_idle_en = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i == 8)  sched_idle_en = 1'b0;
      if (i == 11) sched_idle_en = 1'b1;
      tick();
      checks++;
      if (obs !== exp_all) begin failures++; $display("FAIL abort i=%0d got=%h exp=%h", i, obs, exp_all); end
      if (i == 9) begin
        checks++;
        if (obs !== 38'b10) begin failures++; $display("FAIL abort_idle got=%h exp=2", obs); end
      end
      if (i == 12) begin
        checks++;
        if (idle_symbols[7:0] !== 8'h0F || idle_pattern_start !== 1'b1) begin
          failures++; $display("FAIL abort_restart_sr sym=%h start=%b exp 0f/1", idle_symbols[7:0], idle_pattern_start);
        end
      end
    end
  endtask

  task automatic test_cfg_change();
    go_idle();
    cfg_lane_count = 3'd4; cfg_mvid = 8'h12; sched_idle_en = 1'b1;
    for (int j = 1; j <= 2 * PERIOD; j++) begin
      tick();
      if (j == 3) begin cfg_lane_count = 3'd1; cfg_mvid = 8'h34; end
      checks++;
      if (obs !== exp_all) begin failures++; $display("FAIL cfg_change j=%0d got=%h exp=%h", j, obs, exp_all); end
      if (j == 7 || j == 7 + PERIOD) begin
        checks++;
        if (idle_symbols !== ((j == 7) ? 32'h12121212 : 32'h00000034)) begin
          failures++; $display("FAIL cfg_mvid_latch j=%0d got=%h", j, idle_symbols);
        end
      end
    end
  endtask

  task automatic test_activate();
    logic [15:0] act_seq;
    act_seq = 16'h7FF8;
    go_idle();
    sched_idle_en = 1'b1;
    tick();
    for (int p = 0; p < PERIOD; p++) begin
      tick();
      checks++;
      if (idle_activate_en !== act_seq[p]) begin
        failures++; $display("FAIL activate p=%0d got=%b exp=%b", p, idle_activate_en, act_seq[p]);
      end
    end
  endtask

  task automatic test_async_reset();
    go_idle();
    cfg_lane_count = 3'd4; sched_idle_en = 1'b1;
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 38'd0) begin failures++; $display("FAIL async_reset got=%h exp=0", obs); end
    for (int i = 0; i < PERIOD + 4; i++) begin
      if (i == 2) rst_n = 1'b1;
      tick();
      checks++;
      if (obs !== exp_all) begin failures++; $display("FAIL async_reset_run i=%0d got=%h exp=%h", i, obs, exp_all); end
      if (i == 3) begin
        checks++;
        if (idle_symbols[7:0] !== 8'h0F || idle_pattern_start !== 1'b1) begin
          failures++; $display("FAIL async_reset_sr sym=%h start=%b exp 0f/1", idle_symbols[7:0], idle_pattern_start);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      sched_idle_en  = ($urandom_range(0, 99) < 97);
      cfg_lane_count = 3'($urandom_range(0, 7));
      cfg_mvid       = 8'($urandom);
      cfg_maud       = 8'($urandom);
      tick();
      checks++;
      if (obs !== exp_all) begin failures++; $display("FAIL random i=%0d got=%h exp=%h", i, obs, exp_all); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sr_interval();
    test_abort();
    test_cfg_change();
    test_activate();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/idle_pattern_ml.md
IDLE_PATTERN_ML -- requirements
Module: idle_pattern_ml

Interface
REQ-001 Parameter MAX_LANES, default 4: number of lane symbol slots; legal values are 1, 2 and 4.
REQ-002 Parameter PERIOD, default 8192: symbols per idle pattern per lane; legal range is 16 to 65536.
REQ-003 Parameter SR_INTERVAL, default 512: every SR_INTERVAL-th pattern uses SR in place of BS; legal values are powers of 2, 1 to 1024.
REQ-004 Port clk  in  1: single system clock; all logic is on the rising edge.
REQ-005 Port rst_n  in  1: asynchronous, active-low reset.
REQ-006 Port sched_idle_en  in  1: scheduler enable; while high, patterns run.
REQ-007 Port cfg_lane_count  in  3: active lanes, 1/2/4; any other value is treated as 1.
REQ-008 Port cfg_mvid  in  8: Mvid[7:0] value.
REQ-009 Port cfg_maud  in  8: Maud[7:0] value.
REQ-010 Port idle_symbols  out  8*MAX_LANES: lane n occupies bits [8n+7:8n].
REQ-011 Port idle_control_sym_flag  out  MAX_LANES: per-lane control-symbol (K) flag.
REQ-012 Port idle_activate_en  out  1: switching-availability flag to the scheduler.
REQ-013 Port idle_pattern_start  out  1: one-cycle pulse aligned with each BS1 output.

Function
REQ-014 The FSM SHALL have states IDLE, BS1, BS2, BS3, BS4, VBID, MVID, MAUD and DUMMY.
REQ-015 From IDLE the FSM SHALL move to BS1 when sched_idle_en=1.
REQ-016 The FSM SHALL step BS1->BS2->BS3->BS4->VBID->MVID->MAUD->DUMMY, one state per cycle.
REQ-017 The FSM SHALL stay in DUMMY until the symbol counter reaches PERIOD-1, then go to BS1.
REQ-018 The symbol counter SHALL be 16 bits, 0 in BS1, +1 per cycle, and clear on the DUMMY->BS1 transition; pattern length is exactly PERIOD cycles.
REQ-019 sched_idle_en=0 in any state SHALL force IDLE on the next edge and clear the symbol counter and the pattern counter.
REQ-020 Lane count, cfg_mvid and cfg_maud SHALL be latched on every transition into BS1 and held constant for that pattern.
REQ-021 The pattern counter SHALL count modulo SR_INTERVAL and increment on every DUMMY->BS1 transition.
REQ-022 A pattern SHALL be an SR pattern when it is the first pattern after IDLE or when the pattern counter is 0.
REQ-023 Per-state symbol and flag on every active lane:
- BS1 and BS4: SR (0x0F) in an SR pattern, otherwise BS (0xBC); flag 1.
- BS2 and BS3: BF (0xBD); flag 1.
- VBID: 0x08; flag 0.
- MVID: latched Mvid; flag 0.
- MAUD: latched Maud; flag 0.
- DUMMY: 0x00; flag 0.
REQ-024 Lanes at or above the latched lane count, and all lanes in IDLE, SHALL output symbol 0x00 and flag 0.
REQ-025 idle_activate_en SHALL be:
- 1 in IDLE, BS4, VBID, MVID and MAUD;
- 0 in BS1, BS2 and BS3;
- in DUMMY, 0 on the cycle where counter=PERIOD-1 and 1 otherwise.
REQ-026 All outputs SHALL be registered: the output for the state in cycle t appears in cycle t+1, so latency from sched_idle_en rising to the first BS1/SR output is 2 cycles.
REQ-027 idle_pattern_start SHALL be 1 exactly in the output cycle that carries the BS1 symbol.
REQ-028 Changes to cfg_lane_count, cfg_mvid or cfg_maud mid-pattern SHALL have no effect until the next BS1.
REQ-029 Pattern counter wrap and the first-pattern condition occurring on the same boundary SHALL give one SR pattern, not two.

Reset
REQ-030 While rst_n=0, outputs SHALL be immediately 0: idle_symbols=0, flags=0, idle_activate_en=0, idle_pattern_start=0.
REQ-031 While rst_n=0, internal state SHALL be: FSM=IDLE, counters=0, first-pattern flag=1, latched lane count=1, latched Mvid/Maud=0.
REQ-032 Reset asserted mid-pattern SHALL abort the pattern with no partial completion.
REQ-033 After reset release the block SHALL wait in IDLE; the first IDLE output cycle gives idle_activate_en=1.

Verification (build PERIOD=16, SR_INTERVAL=4, MAX_LANES=4)
REQ-034 Lanes=4, enable from reset -> lane0..3 carry 0F,BD,BD,0F,08,Mvid,Maud, then nine 00; flags 1111 on the first four symbols only; idle_pattern_start pulses once.
REQ-035 Lanes=2, run 5 patterns -> SR on patterns 1 and 5 and BS (0xBC) on patterns 2-4; lanes 2-3 stay 0x00 with flag 0; patterns are 16 cycles apart.
REQ-036 Drop enable at counter=7, re-raise after 3 cycles -> outputs go 0, idle_activate_en=1, and the next pattern starts with SR.
REQ-037 Change cfg_lane_count from 4 to 1 and cfg_mvid from 0x12 to 0x34 at counter=2 -> the current pattern keeps 4 lanes and Mvid 0x12; the next pattern uses 1 lane and 0x34.
REQ-038 Check idle_activate_en over one pattern -> sequence 0,0,0,1,1,1,1,1x8,0.
REQ-039 Assert rst_n=0 asynchronously during BS2 -> all outputs 0 without waiting for a clock edge; after release with enable high, an SR pattern starts 2 cycles later.
